// File: rtl/reg_cmd_ctrl.sv
// Command front end for RegFile: parses write/read frames from the serial
// receiver, strobes the RegFile, and forwards read data to the transmitter.
module reg_cmd_ctrl #(
  parameter int unsigned                  DATA_WIDTH    = 8,
  parameter int unsigned                  ADDRESS_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]        WR_CMD        = DATA_WIDTH'(8'hAA),
  parameter logic [DATA_WIDTH-1:0]        RD_CMD        = DATA_WIDTH'(8'hBB),
  parameter int unsigned                  RD_TIMEOUT    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     TX_READY,
  output logic                     CMD_ERR,
  output logic                     BUSY
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     wr_en_q;
  logic                     rd_en_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic [DATA_WIDTH-1:0]    tx_data_q;
  logic                     tx_vld_q;
  logic                     cmd_err_q;
  logic                     busy_q;

  // Frame parser FSM; every output is a register, BUSY tracks the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      address_q <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == WR_CMD) begin
              state_q <= WR_ADDR;
              busy_q  <= 1'b1;
            end else if (RX_P_DATA == RD_CMD) begin
              state_q <= RD_ADDR;
              busy_q  <= 1'b1;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_q  <= RX_P_DATA[ADDRESS_WIDTH-1:0];
            state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            wr_en_q   <= 1'b1;
            address_q <= addr_q;
            wr_data_q <= RX_P_DATA;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            rd_en_q   <= 1'b1;
            address_q <= RX_P_DATA[ADDRESS_WIDTH-1:0];
            cnt_q     <= '0;
            state_q   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Bytes arriving while a read is outstanding are dropped and flagged.
          cmd_err_q <= RX_D_VLD;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (RdData_Valid) begin
            tx_data_q <= RdData;
            tx_vld_q  <= 1'b1;
            state_q   <= TX_SEND;
          end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
            cmd_err_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        TX_SEND: begin
          cmd_err_q <= RX_D_VLD;
          if (TX_READY) begin
            tx_vld_q <= 1'b0;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = cmd_err_q;
  assign BUSY      = busy_q;

endmodule
